anim_seq_ctrl: RTL and testbench
================================

Name: anim_seq_ctrl

Overview:
- Sprite animation sequencer that drives the character-sprite controls of the VGA address generator: `frame_idx`, `is_moving` and `face_left`.
- Turns joystick direction levels into an IDLE/WALK animation state machine with per-state frame counts and playback rates.
- Advances once per video frame, on the rising edge of `vsync`, so sprite controls change only during vertical blanking.
- Sits between the input/control logic and the address generator, in the 25 MHz pixel-clock domain.

Parameters:
- IDLE_FRAMES, 4: frames in the idle strip (128 px wide / 32).
- WALK_FRAMES, 6: frames in the walk strip (192 px wide / 32).
- IDLE_TICKS, 8: vsync ticks per idle frame.
- WALK_TICKS, 5: vsync ticks per walk frame.
- STOP_HOLD, 3: consecutive no-input ticks before dropping from walk to idle.
- Legal ranges: FRAMES 1..8; TICKS 1..16; STOP_HOLD 1..16.

Ports:
- clk in 1: 25 MHz pixel clock.
- rst_n in 1: asynchronous, active-low reset.
- vsync in 1: VGA vertical sync, synchronous to clk.
- dir_left in 1: joystick left level, asynchronous.
- dir_right in 1: joystick right level, asynchronous.
- freeze in 1: level; holds all animation state (pause / level clear).
- frame_idx out 3: current animation frame to the address generator.
- is_moving out 1: 1 = walk strip, 0 = idle strip.
- face_left out 1: 1 = mirror the sprite horizontally.
- frame_tick out 1: one-cycle pulse on each detected vsync rising edge.

Behaviour:
- Reset is asynchronous and active-low; every flop is reset.
- Reset values:
  - frame_idx = 0, is_moving = 0, face_left = 0, frame_tick = 0.
  - State = IDLE; tick_cnt = 0; hold_cnt = 0; synchroniser flops = 0.
  - vsync_d = 1, so a vsync that is already high at reset release produces no tick.
- Input sync: dir_left and dir_right each pass through a 2-flop synchroniser. Only the synchronised values are used.
- Tick detection: tick = vsync & ~vsync_d. frame_tick is tick registered, so it pulses 1 cycle after the vsync edge sample.
- Direction decode: active = L xor R. Both pressed or neither pressed counts as no input. want_left = L.
- Update timing:
  - All state, counters and outputs update only on a tick with freeze = 0.
  - Outputs are registered and valid in the cycle after tick, the same cycle frame_tick is high.
  - Between ticks, all outputs are stable.
- freeze = 1 on a tick: nothing changes, including the synchroniser-sampled direction effect. frame_tick still pulses.
- advance(F, T):
  - If tick_cnt == T-1: tick_cnt = 0, and frame_idx = (frame_idx == F-1) ? 0 : frame_idx + 1.
  - Otherwise: tick_cnt++.
- IDLE (is_moving = 0):
  - active: go to WALK; frame_idx = 0; tick_cnt = 0; face_left = want_left.
  - else: advance(IDLE_FRAMES, IDLE_TICKS).
- WALK (is_moving = 1):
  - active: face_left = want_left; advance(WALK_FRAMES, WALK_TICKS). A reversal does not restart the frame sequence.
  - no input: if STOP_HOLD == 1, go to IDLE with frame_idx = 0, tick_cnt = 0, face_left kept. Otherwise go to STOP with hold_cnt = 1 and advance(WALK_FRAMES, WALK_TICKS).
- STOP (is_moving = 1):
  - active: go to WALK; hold_cnt = 0; face_left = want_left; advance (no frame reset).
  - no input and hold_cnt == STOP_HOLD-1: go to IDLE; frame_idx = 0; tick_cnt = 0; hold_cnt = 0.
  - no input otherwise: hold_cnt++; advance(WALK_FRAMES, WALK_TICKS).
- Invariant: frame_idx < frame count of the current strip at all times. Every IDLE↔WALK change resets frame_idx to 0.
- Reset asserted mid-operation returns immediately to the reset values. No tick is taken on release, even if vsync is high.

Test Plan:
- Reset release with vsync held high, no input → no frame_tick; all outputs 0.
- Idle playback, no input: 8 ticks → frame_idx = 1; 32 ticks → frame_idx = 0 (wrap); is_moving stays 0.
- Walk entry: dir_right = 1, stable ≥ 2 clk before a tick → after that tick is_moving = 1, frame_idx = 0, face_left = 0. 5 more ticks → frame_idx = 1. 30 ticks → frame_idx = 0.
- Reversal: switch to dir_left at walk frame_idx = 3 → next tick face_left = 1, frame_idx continues 3→4 on schedule.
- Stop hysteresis:
  - Release all inputs → is_moving = 1 after ticks 1 and 2, is_moving = 0 with frame_idx = 0 after tick 3.
  - Re-press at tick 2 → stays WALK, frame not reset.
- Edge cases:
  - Both directions pressed → treated as release.
  - freeze = 1 for 10 ticks → outputs unchanged, frame_tick pulses 10 times.
  - rst_n pulse mid-walk → outputs 0 asynchronously.

Source files
------------

// File: rtl/anim_seq_ctrl.sv
// anim_seq_ctrl: sprite animation sequencer for the VGA address generator.
// Converts joystick direction levels into an IDLE / WALK / STOP animation
// state machine and advances it once per video frame (rising edge of vsync),
// so frame_idx, is_moving and face_left only ever change during blanking.

module anim_seq_ctrl #(
    parameter int IDLE_FRAMES = 4,  // frames in the idle strip (1..8)
    parameter int WALK_FRAMES = 6,  // frames in the walk strip (1..8)
    parameter int IDLE_TICKS  = 8,  // vsync ticks per idle frame (1..16)
    parameter int WALK_TICKS  = 5,  // vsync ticks per walk frame (1..16)
    parameter int STOP_HOLD   = 3   // no-input ticks before walk drops to idle (1..16)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       dir_left,
    input  logic       dir_right,
    input  logic       freeze,
    output logic [2:0] frame_idx,
    output logic       is_moving,
    output logic       face_left,
    output logic       frame_tick
);

    // Last legal value of each counter, pre-sized to the counter widths.
    localparam logic [2:0] IDLE_FLAST = 3'(IDLE_FRAMES - 1);
    localparam logic [2:0] WALK_FLAST = 3'(WALK_FRAMES - 1);
    localparam logic [3:0] IDLE_TLAST = 4'(IDLE_TICKS - 1);
    localparam logic [3:0] WALK_TLAST = 4'(WALK_TICKS - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(STOP_HOLD - 1);

    // STOP is a walk-strip state that counts consecutive no-input ticks.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    // Playback position inside the current strip.
    typedef struct packed {
        logic [2:0] frame;
        logic [3:0] tick;
    } pos_t;

    // One playback step: count ticks within a frame, then step the frame,
    // wrapping at the end of the strip.
    function automatic pos_t advance(input pos_t cur,
                                     input logic [2:0] flast,
                                     input logic [3:0] tlast);
        pos_t nxt;
        if (cur.tick == tlast) begin
            nxt.tick  = 4'd0;
            nxt.frame = (cur.frame == flast) ? 3'd0 : cur.frame + 3'd1;
        end else begin
            nxt.tick  = cur.tick + 4'd1;
            nxt.frame = cur.frame;
        end
        return nxt;
    endfunction

    // Synchroniser stages for the asynchronous joystick levels.
    logic left_meta, left_sync;
    logic right_meta, right_sync;

    // vsync edge detection.
    logic vsync_d;
    logic tick;

    // Animation state, current and next.
    state_t     state_q, state_d;
    pos_t       pos_q, pos_d;
    logic [3:0] hold_q, hold_d;
    logic       face_q, face_d;

    // Decoded direction and candidate playback steps.
    logic active;
    logic want_left;
    pos_t idle_step;
    pos_t walk_step;

    assign tick      = vsync & ~vsync_d;
    assign active    = left_sync ^ right_sync;
    assign want_left = left_sync;

    // Two-flop synchronisers bring dir_left / dir_right into the clk domain.
    // NOTE: every flop, synchroniser stages included, is cleared by the async
    // reset so the block comes up in a known state with no X propagation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_meta  <= 1'b0;
            left_sync  <= 1'b0;
            right_meta <= 1'b0;
            right_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the second stage pick up the
            // first stage's old value, which is what makes this a two-flop chain.
            left_meta  <= dir_left;
            left_sync  <= left_meta;
            right_meta <= dir_right;
            right_sync <= right_meta;
        end
    end

    // Delayed vsync for edge detection and the registered frame_tick pulse;
    // vsync_d resets high so a vsync already high at release gives no tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vsync_d    <= vsync;
            frame_tick <= tick;
        end
    end

    // Animation state register; loads the next state on every clock, which
    // only differs from the current state on an unfrozen tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            hold_q  <= 4'd0;
            face_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            hold_q  <= hold_d;
            face_q  <= face_d;
        end
    end

    // Next-state logic: idle playback, walk entry, reversal and stop hysteresis.
    always_comb begin
        // NOTE: hold-current defaults assigned first keep every path fully
        // specified, so no latches are inferred for the untouched fields.
        state_d   = state_q;
        pos_d     = pos_q;
        hold_d    = hold_q;
        face_d    = face_q;
        idle_step = advance(pos_q, IDLE_FLAST, IDLE_TLAST);
        walk_step = advance(pos_q, WALK_FLAST, WALK_TLAST);

        if (tick && !freeze) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (active) begin
                        // Strip change: restart the walk strip from frame 0.
                        state_d = ST_WALK;
                        pos_d   = '0;
                        face_d  = want_left;
                    end else begin
                        pos_d = idle_step;
                    end
                end

                ST_WALK: begin
                    if (active) begin
                        // A reversal only mirrors the sprite; playback continues.
                        face_d = want_left;
                        pos_d  = walk_step;
                    end else if (STOP_HOLD == 1) begin
                        state_d = ST_IDLE;
                        pos_d   = '0;
                    end else begin
                        state_d = ST_STOP;
                        hold_d  = 4'd1;
                        pos_d   = walk_step;
                    end
                end

                ST_STOP: begin
                    if (active) begin
                        // Re-press during hysteresis resumes walking in place.
                        state_d = ST_WALK;
                        hold_d  = 4'd0;
                        face_d  = want_left;
                        pos_d   = walk_step;
                    end else if (hold_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                        pos_d   = '0;
                        hold_d  = 4'd0;
                    end else begin
                        hold_d = hold_q + 4'd1;
                        pos_d  = walk_step;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    pos_d   = '0;
                    hold_d  = 4'd0;
                end
            endcase
        end
    end

    assign frame_idx = pos_q.frame;
    assign is_moving = (state_q != ST_IDLE);
    assign face_left = face_q;

endmodule

// File: tb/tb_anim_seq_ctrl.sv
// Self-checking bench for anim_seq_ctrl: directed scenarios with hand-computed
// expectations, then randomized joystick / freeze / vsync / reset traffic,
// all compared every cycle against a tick-counting behavioural model.

module tb_anim_seq_ctrl;

    localparam int IDLE_FRAMES = 4;
    localparam int WALK_FRAMES = 6;
    localparam int IDLE_TICKS  = 8;
    localparam int WALK_TICKS  = 5;
    localparam int STOP_HOLD   = 3;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       vsync     = 1'b1;
    logic       dir_left  = 1'b0;
    logic       dir_right = 1'b0;
    logic       freeze    = 1'b0;
    logic [2:0] frame_idx;
    logic       is_moving;
    logic       face_left;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    int ft_cnt = 0;

    anim_seq_ctrl #(
        .IDLE_FRAMES(IDLE_FRAMES),
        .WALK_FRAMES(WALK_FRAMES),
        .IDLE_TICKS (IDLE_TICKS),
        .WALK_TICKS (WALK_TICKS),
        .STOP_HOLD  (STOP_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vsync     (vsync),
        .dir_left  (dir_left),
        .dir_right (dir_right),
        .freeze    (freeze),
        .frame_idx (frame_idx),
        .is_moving (is_moving),
        .face_left (face_left),
        .frame_tick(frame_tick)
    );

    // 25 MHz pixel clock (40 time units per period).
    always #20 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model. Playback is a single counter m_pos of ticks spent in
    // the current strip, modulo (frames * ticks); the shown frame is
    // m_pos / ticks. Stop hysteresis is a count of consecutive no-input ticks.
    // ---------------------------------------------------------------------
    bit m_moving = 0;
    bit m_face   = 0;
    bit m_tick   = 0;
    int m_pos    = 0;
    int m_streak = 0;
    bit l_h1 = 0, l_h2 = 0, r_h1 = 0, r_h2 = 0;
    bit v_prev = 1;

    function automatic logic [7:0] model_vec();
        int f;
        f = m_moving ? (m_pos / WALK_TICKS) : (m_pos / IDLE_TICKS);
        return {2'b00, 3'(f), m_moving, m_face, m_tick};
    endfunction

    initial begin : model
        bit tk, act, wl;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_moving = 0; m_face = 0; m_tick = 0; m_pos = 0; m_streak = 0;
                l_h1 = 0; l_h2 = 0; r_h1 = 0; r_h2 = 0; v_prev = 1;
            end else begin
                tk     = vsync && !v_prev;
                v_prev = vsync;
                // Direction seen by the design is the one sampled two edges ago.
                act    = l_h2 ^ r_h2;
                wl     = l_h2;
                l_h2   = l_h1; l_h1 = dir_left;
                r_h2   = r_h1; r_h1 = dir_right;
                m_tick = tk;
                if (tk && !freeze) begin
                    if (!m_moving) begin
                        if (act) begin
                            m_moving = 1; m_pos = 0; m_face = wl; m_streak = 0;
                        end else begin
                            m_pos = (m_pos + 1) % (IDLE_FRAMES * IDLE_TICKS);
                        end
                    end else if (act) begin
                        m_face   = wl;
                        m_streak = 0;
                        m_pos    = (m_pos + 1) % (WALK_FRAMES * WALK_TICKS);
                    end else begin
                        m_streak++;
                        if (m_streak >= STOP_HOLD) begin
                            m_moving = 0; m_pos = 0; m_streak = 0;
                        end else begin
                            m_pos = (m_pos + 1) % (WALK_FRAMES * WALK_TICKS);
                        end
                    end
                end
            end
        end
    end

    // Compare process: DUT against model on every falling edge out of reset.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("model", {2'b00, frame_idx, is_moving, face_left, frame_tick}, model_vec());
                if (frame_tick) ft_cnt++;
            end
        end
    end

    // Directed helpers (called at a falling edge, return at a falling edge).
    task automatic vtick(input int n);
        for (int i = 0; i < n; i++) begin
            vsync = 1'b1;
            @(negedge clk);
            vsync = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic set_dir(input logic l, input logic r);
        dir_left  = l;
        dir_right = r;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_out(input string name, input int f, input bit m, input bit fl);
        check(name, {3'b000, frame_idx, is_moving, face_left}, {3'b000, 3'(f), m, fl});
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int ft0;

        // Reset release with vsync already high: no tick, everything 0.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_release", {4'b0, frame_idx, is_moving, face_left, frame_tick}, 8'h00);
        end
        vsync = 1'b0;
        repeat (2) @(negedge clk);

        // Idle playback and wrap.
        vtick(8);  chk_out("idle_8", 1, 0, 0);
        vtick(24); chk_out("idle_32_wrap", 0, 0, 0);

        // Walk entry, playback and wrap.
        set_dir(0, 1);
        vtick(1);  chk_out("walk_entry", 0, 1, 0);
        vtick(5);  chk_out("walk_5", 1, 1, 0);
        vtick(25); chk_out("walk_30_wrap", 0, 1, 0);

        // Reversal at frame 3 keeps the schedule.
        vtick(19); chk_out("walk_f3", 3, 1, 0);
        set_dir(1, 0);
        vtick(1);  chk_out("reversal", 4, 1, 1);

        // Stop hysteresis.
        set_dir(0, 0);
        vtick(1);  chk_out("stop_1", 4, 1, 1);
        vtick(1);  chk_out("stop_2", 4, 1, 1);
        vtick(1);  chk_out("stop_3_idle", 0, 0, 1);

        // Re-press during hysteresis stays in walk without a frame reset.
        set_dir(0, 1);
        vtick(1);  chk_out("rewalk_entry", 0, 1, 0);
        set_dir(0, 0);
        vtick(2);  chk_out("rewalk_release2", 0, 1, 0);
        set_dir(0, 1);
        vtick(3);  chk_out("repress_no_reset", 1, 1, 0);
        set_dir(0, 0);
        vtick(2);  chk_out("hold_restarted", 1, 1, 0);
        set_dir(0, 1);
        vtick(1);  chk_out("walk_p8", 1, 1, 0);

        // Both directions pressed counts as release.
        set_dir(1, 1);
        vtick(2);  chk_out("both_hold", 2, 1, 0);
        vtick(1);  chk_out("both_idle", 0, 0, 0);

        // Freeze: inputs ignored, outputs held, frame_tick still pulses.
        set_dir(0, 0);
        vtick(9);  chk_out("pre_freeze", 1, 0, 0);
        freeze = 1'b1;
        set_dir(1, 0);
        ft0 = ft_cnt;
        vtick(10);
        check("freeze_ticks", 8'(ft_cnt - ft0), 8'd10);
        chk_out("freeze_hold", 1, 0, 0);
        freeze = 1'b0;
        set_dir(0, 0);

        // Asynchronous reset mid-walk with vsync high across release.
        set_dir(0, 1);
        vtick(1);  chk_out("walk_again", 0, 1, 0);
        vtick(6);  chk_out("walk_again_6", 1, 1, 0);
        dir_right = 1'b0;
        vsync = 1'b1;
        #5 rst_n = 1'b0;
        #1 check("async_reset", {4'b0, frame_idx, is_moving, face_left, frame_tick}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_tick_on_release", {7'b0, frame_tick}, 8'h00);
        end
        vsync = 1'b0;
        repeat (3) @(negedge clk);

        // Randomized traffic against the model.
        for (int it = 0; it < 800; it++) begin
            if ($urandom_range(0, 9) < 4) begin
                dir_left  = 1'($urandom_range(0, 1));
                dir_right = 1'($urandom_range(0, 1));
            end
            freeze = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            vsync = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            vsync = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
